// File: rtl/alarm_pkg.sv
// alarm_pkg
// Shared types and constants for the alarm_bank slice.
//   state_t      : ringing FSM states (IDLE, RING)
//   bcd_time_t   : packed BCD HH:MM {h1[1:0], h0[3:0], m1[3:0], m0[3:0]}
//   MAX_HOUR, MAX_MIN_TENS, SNOOZE_MIN_DEFAULT : BCD limits and snooze default
//   time_is_valid() : range check of a BCD HH:MM value
package alarm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } state_t;

    localparam int MAX_HOUR           = 23;
    localparam int MAX_MIN_TENS       = 5;
    localparam int SNOOZE_MIN_DEFAULT = 5;

    // Split of the hour limit into its BCD digits.
    localparam int HOUR_TENS_MAX  = MAX_HOUR / 10;
    localparam int HOUR_UNITS_MAX = MAX_HOUR % 10;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_time_t;

    function automatic logic time_is_valid(input bcd_time_t t);
        logic hour_ok;
        hour_ok = (t.h1 < 2'(HOUR_TENS_MAX)) ||
                  ((t.h1 == 2'(HOUR_TENS_MAX)) && (t.h0 <= 4'(HOUR_UNITS_MAX)));
        return hour_ok && (t.h0 <= 4'd9) && (t.m1 <= 4'(MAX_MIN_TENS)) && (t.m0 <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// bcd_time_add
// Combinational BCD HH:MM + ADD_MIN minutes (ADD_MIN in 1..9).
// Minutes wrap 59->00 with an hour carry; 23:59 wraps to 00:0x.
// Only instantiated by alarm_bank when ALARM_SNOOZE_EN is defined.
//   t_in  : bcd_time_t  input time (assumed valid)
//   t_out : bcd_time_t  t_in + ADD_MIN
module bcd_time_add
    import alarm_pkg::*;
#(
    parameter int ADD_MIN = SNOOZE_MIN_DEFAULT
) (
    input  bcd_time_t t_in,
    output bcd_time_t t_out
);

    logic [4:0] m0_sum;
    logic       min_carry;
    logic       hour_carry;

    always_comb begin
        t_out      = t_in;
        min_carry  = 1'b0;
        hour_carry = 1'b0;
        m0_sum     = 5'(t_in.m0) + 5'(ADD_MIN);

        // ADD_MIN <= 9, so at most one decimal carry out of the minute units.
        if (m0_sum >= 5'd10) begin
            t_out.m0  = 4'(m0_sum - 5'd10);
            min_carry = 1'b1;
        end else begin
            t_out.m0 = m0_sum[3:0];
        end

        if (min_carry) begin
            if (t_in.m1 >= 4'(MAX_MIN_TENS)) begin
                t_out.m1   = 4'd0;
                hour_carry = 1'b1;
            end else begin
                t_out.m1 = t_in.m1 + 4'd1;
            end
        end

        if (hour_carry) begin
            if ((t_in.h1 == 2'(HOUR_TENS_MAX)) && (t_in.h0 == 4'(HOUR_UNITS_MAX))) begin
                t_out.h1 = 2'd0;
                t_out.h0 = 4'd0;
            end else if (t_in.h0 == 4'd9) begin
                t_out.h1 = t_in.h1 + 2'd1;
                t_out.h0 = 4'd0;
            end else begin
                t_out.h0 = t_in.h0 + 4'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// alarm_bank
// NUM_ALARMS independently loadable BCD alarm slots compared against the
// running clock time; rings with the index of the lowest hitting slot.
// Optional snooze feature: define ALARM_SNOOZE_EN.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   H_in1/H_in0/M_in1/M_in0         : BCD time to load
//   slot_sel                        : slot for load / clear / read-back
//   LD_alarm, CLR_alarm             : load+enable / disable slot_sel (load wins)
//   c_hour1/c_hour0/c_min1/c_min0   : current BCD clock time
//   stop_alarm, snooze              : silence ring / snooze request
//   a_hour1/a_hour0/a_min1/a_min0   : registered read-back of slot_sel
//   a_valid                         : registered enable of slot_sel
//   ld_err                          : one-cycle pulse after a rejected load
//   alarm, ring_slot                : ringing flag and triggering slot
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int SEL_W      = $clog2(NUM_ALARMS),
    parameter int SNOOZE_MIN = SNOOZE_MIN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       H_in1,
    input  logic [3:0]       H_in0,
    input  logic [3:0]       M_in1,
    input  logic [3:0]       M_in0,
    input  logic [SEL_W-1:0] slot_sel,
    input  logic             LD_alarm,
    input  logic             CLR_alarm,
    input  logic [1:0]       c_hour1,
    input  logic [3:0]       c_hour0,
    input  logic [3:0]       c_min1,
    input  logic [3:0]       c_min0,
    input  logic             stop_alarm,
    input  logic             snooze,
    output logic [1:0]       a_hour1,
    output logic [3:0]       a_hour0,
    output logic [3:0]       a_min1,
    output logic [3:0]       a_min0,
    output logic             a_valid,
    output logic             ld_err,
    output logic             alarm,
    output logic [SEL_W-1:0] ring_slot
);

    bcd_time_t             cur_time;
    bcd_time_t             ld_time;
    bcd_time_t             prev_time_reg;
    bcd_time_t             slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] slot_en;
    logic [NUM_ALARMS-1:0] hit;
    logic                  sel_ok;
    logic                  ld_ok;
    logic                  time_changed;
    logic [SEL_W-1:0]      hit_idx;

    state_t                state_reg, state_next;
    logic [SEL_W-1:0]      ring_slot_reg, ring_slot_next;
    bcd_time_t             rd_time_reg;
    logic                  rd_valid_reg;
    logic                  ld_err_reg;

    assign cur_time = {c_hour1, c_hour0, c_min1, c_min0};
    assign ld_time  = {H_in1, H_in0, M_in1, M_in0};

    // slot_sel can exceed NUM_ALARMS-1 when NUM_ALARMS is not a power of two.
    assign sel_ok       = (int'(slot_sel) < NUM_ALARMS);
    assign ld_ok        = LD_alarm && sel_ok && time_is_valid(ld_time);
    // Hits are qualified by a change of the current time so a match fires
    // once on the minute boundary instead of for the whole minute.
    assign time_changed = (cur_time != prev_time_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
            bcd_time_t time_reg;
            logic      en_reg;
            logic      addressed;

            assign addressed = sel_ok && (int'(slot_sel) == gi);

            always_ff @(posedge clk) begin
                if (reset) begin
                    time_reg <= '0;
                    en_reg   <= 1'b0;
                end else if (addressed && ld_ok) begin
                    time_reg <= ld_time;
                    en_reg   <= 1'b1;
                end else if (addressed && CLR_alarm) begin
                    en_reg   <= 1'b0;
                end
            end

            assign slot_time[gi] = time_reg;
            assign slot_en[gi]   = en_reg;
            assign hit[gi]       = en_reg && (time_reg == cur_time) && time_changed;
        end
    endgenerate

    // Lowest hitting index wins: scan downwards so the last assignment is the lowest.
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Read-back bypasses the slot array on a load/clear so the new contents
    // are visible the cycle right after the command.
    always_ff @(posedge clk) begin
        if (reset || !sel_ok) begin
            rd_time_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else if (ld_ok) begin
            rd_time_reg  <= ld_time;
            rd_valid_reg <= 1'b1;
        end else begin
            rd_time_reg  <= slot_time[slot_sel];
            rd_valid_reg <= slot_en[slot_sel] && !CLR_alarm;
        end
    end

`ifdef ALARM_SNOOZE_EN
    logic             snooze_active_reg, snooze_active_next;
    bcd_time_t        snooze_time_reg, snooze_time_next;
    logic [SEL_W-1:0] snooze_slot_reg, snooze_slot_next;
    bcd_time_t        snooze_sum;
    logic             snooze_hit;

    bcd_time_add #(
        .ADD_MIN (SNOOZE_MIN)
    ) u_snooze_add (
        .t_in  (cur_time),
        .t_out (snooze_sum)
    );

    assign snooze_hit = snooze_active_reg && (snooze_time_reg == cur_time) && time_changed;

    always_ff @(posedge clk) begin
        if (reset) begin
            snooze_active_reg <= 1'b0;
            snooze_time_reg   <= '0;
            snooze_slot_reg   <= '0;
        end else begin
            snooze_active_reg <= snooze_active_next;
            snooze_time_reg   <= snooze_time_next;
            snooze_slot_reg   <= snooze_slot_next;
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = snooze | (SNOOZE_MIN == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ring_slot_reg <= '0;
            prev_time_reg <= '0;
            ld_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ring_slot_reg <= ring_slot_next;
            prev_time_reg <= cur_time;
            ld_err_reg    <= LD_alarm && !time_is_valid(ld_time);
        end
    end

    always_comb begin
        state_next     = state_reg;
        ring_slot_next = ring_slot_reg;
`ifdef ALARM_SNOOZE_EN
        snooze_active_next = snooze_active_reg;
        snooze_time_next   = snooze_time_reg;
        snooze_slot_next   = snooze_slot_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|hit) begin
                    state_next     = RING;
                    ring_slot_next = hit_idx;
                end
`ifdef ALARM_SNOOZE_EN
                // Snooze re-ring overrides a simultaneous slot hit.
                if (snooze_hit && !stop_alarm) begin
                    state_next         = RING;
                    ring_slot_next     = snooze_slot_reg;
                    snooze_active_next = 1'b0;
                end
                if (stop_alarm) begin
                    snooze_active_next = 1'b0;
                end
`endif
            end
            RING: begin
                if (stop_alarm) begin
                    state_next = IDLE;
`ifdef ALARM_SNOOZE_EN
                    snooze_active_next = 1'b0;
`endif
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze) begin
                    state_next         = IDLE;
                    snooze_active_next = 1'b1;
                    snooze_time_next   = snooze_sum;
                    snooze_slot_next   = ring_slot_reg;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign a_hour1   = rd_time_reg.h1;
    assign a_hour0   = rd_time_reg.h0;
    assign a_min1    = rd_time_reg.m1;
    assign a_min0    = rd_time_reg.m0;
    assign a_valid   = rd_valid_reg;
    assign ld_err    = ld_err_reg;
    assign alarm     = (state_reg == RING);
    assign ring_slot = ring_slot_reg;

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-slot successor to the single alarm-time register. Holds NUM_ALARMS independently loadable BCD alarm times (HH:MM), validates every load and compares all enabled slots against the running clock time. Raises a ringing flag with the index of the triggering slot. Sits between the user-input decoder and the display/buzzer driver of the alarm clock.

## Interface
Parameters:
- NUM_ALARMS, 4, number of alarm slots (2..16).
- SEL_W, $clog2(NUM_ALARMS), slot index width; derived, never overridden.
- SNOOZE_MIN, 5, snooze offset in minutes (1..9); used only with ALARM_SNOOZE_EN.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- H_in1 / H_in0 / M_in1 / M_in0  in  2/4/4/4  BCD alarm time to load.
- slot_sel  in  SEL_W  slot addressed by load, clear and read-back.
- LD_alarm  in  1  load the H/M inputs into slot_sel and enable it.
- CLR_alarm  in  1  disable slot_sel.
- c_hour1 / c_hour0 / c_min1 / c_min0  in  2/4/4/4  current BCD clock time.
- stop_alarm  in  1  silence ringing; cancels pending snooze.
- snooze  in  1  snooze request; ignored without ALARM_SNOOZE_EN.
- a_hour1 / a_hour0 / a_min1 / a_min0  out  2/4/4/4  registered read-back of slot_sel.
- a_valid  out  1  registered enable bit of slot_sel.
- ld_err  out  1  one-cycle pulse: LD_alarm rejected.
- alarm  out  1  ringing.
- ring_slot  out  SEL_W  slot that caused the current ring.

## Operation
- Reset: all slots cleared to 00:00 and disabled; state IDLE; every output 0; snooze inactive.
- Load: LD_alarm with valid time (hours 00–23, H_in0 ≤ 9, M_in1 ≤ 5, M_in0 ≤ 9) writes slot_sel and sets its enable. Invalid time: no write, ld_err=1 for exactly one cycle.
- Clear: CLR_alarm drops the enable of slot_sel; stored time is kept. LD_alarm and CLR_alarm together: load wins.
- Hit: slot i hits when enabled, its time equals the current time, and the previous-cycle current time differed. A hit fires once per minute boundary, never continuously.
- FSM IDLE → RING on any hit: ring_slot = lowest hitting index; alarm=1. In RING, further hits are dropped.
- RING → IDLE on stop_alarm.
- Loading or clearing the ringing slot does not stop the ring.
- reset in any state returns to IDLE at once.

## Timing
- Read-back outputs update one cycle after slot_sel or a load changes; a same-cycle load is visible the next cycle.
- alarm and ring_slot assert on the edge after the current-time inputs move to the match value; latency 1 cycle.
- stop_alarm: alarm=0 on the next edge.
- ld_err is registered: asserted the cycle after the rejected LD_alarm.

## Configuration
- ALARM_SNOOZE_EN defined:
  - snooze in RING stores current time + SNOOZE_MIN in BCD, wrapping 59→00 with hour carry and 23:59→00:0x. It records ring_slot, sets snooze active and returns to IDLE.
  - When the snooze time is hit (same edge rule), the FSM enters RING with the recorded ring_slot. Snooze active clears on this re-ring.
  - Snooze hit and slot hit on the same edge: the snooze slot is reported.
  - stop_alarm together with snooze: stop wins and snooze is cleared.
- Undefined: snooze port ignored; no snooze register or adder is synthesised.

## Structure
- Package alarm_pkg: FSM state enum (IDLE, RING), BCD limit constants (max hour 23, max minute-tens 5), SNOOZE_MIN default.
- Sub-module bcd_time_add: combinational HH:MM + minutes with BCD wrap; instantiated only under ALARM_SNOOZE_EN.

## Test plan
- Reset, then load slot 2 = 21:42, select slot 2 → a_hour1=2, a_hour0=1, a_min1=4, a_min0=2, a_valid=1 one cycle later; slot 0 reads 00:00, a_valid=0.
- Load 24:00, then 10:60 → ld_err pulses once per attempt; slot contents unchanged.
- Slot 1 = 10:24 enabled; current time steps 10:23→10:24 → alarm=1, ring_slot=1 one cycle later. Hold 10:24 after stop_alarm → no re-trigger.
- Slots 0 and 3 both 06:00; time reaches 06:00 → ring_slot=0. Clear slot 0, re-run → ring_slot=3.
- Assert reset mid-ring → alarm=0 and all slots disabled on the next edge.
- With ALARM_SNOOZE_EN: ring at 23:58, snooze → IDLE. Time reaches 00:03 → alarm=1, same ring_slot. stop+snooze together → no re-ring.
